// File: rtl/cpu_pkg.sv
// Definitions shared by the instruction decoder and the I/O / interrupt sequencer:
// the I/O opcode encodings, the sequencer state type and its debug view.
package cpu_pkg;

  localparam logic [4:0] OP_IN  = 5'b11000;
  localparam logic [4:0] OP_OUT = 5'b11001;
  localparam logic [4:0] OP_RFI = 5'b11010;
  localparam logic [4:0] OP_SFO = 5'b11011;
  localparam logic [4:0] OP_RFO = 5'b11100;
  localparam logic [4:0] OP_ION = 5'b11101;
  localparam logic [4:0] OP_IOF = 5'b11110;
  localparam logic [4:0] OP_HLT = 5'b11111;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    SAVE   = 2'd1,
    VEC    = 2'd2,
    HALTED = 2'd3
  } state_t;

  // Observation bundle: current sequencer state and a registered copy of the IN strobe.
  typedef struct packed {
    state_t state;
    logic   in_rd_seen;
  } dbg_t;

endpackage

// File: rtl/io_port_regs.sv
// Input holding register with FGI and output holding register with out_valid/FGO.
// All strobes arrive already qualified by instruction boundary and RUN state.
module io_port_regs #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              rfi,
  input  logic              out_wr,
  input  logic [DATA_W-1:0] out_wdata,
  input  logic              sfo,
  input  logic              rfo,
  input  logic              out_ready,
  output logic              in_ready,
  output logic [DATA_W-1:0] inpr,
  output logic              fgi,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              fgo
);

  logic in_accept;
  logic out_load;
  logic out_done;

  assign in_accept = in_valid && !fgi;
  assign out_load  = out_wr && !out_valid;
  assign out_done  = out_valid && out_ready;
  assign in_ready  = !fgi;

  always_ff @(posedge clk) begin
    if (reset) begin
      inpr <= '0;
      fgi  <= 1'b0;
    end else begin
      if (in_accept) begin
        inpr <= in_data;
      end
      // An accept sets FGI even when rFI lands in the same cycle.
      if (in_accept) begin
        fgi <= 1'b1;
      end else if (rfi) begin
        fgi <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      fgo       <= 1'b1;
    end else begin
      if (out_load) begin
        out_data  <= out_wdata;
        out_valid <= 1'b1;
      end else if (out_done) begin
        out_valid <= 1'b0;
      end
      // Later assignments take priority: rFO overrides a device completion.
      if (out_done || sfo) begin
        fgo <= 1'b1;
      end
      if (out_load || rfo) begin
        fgo <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/io_intr_sequencer.sv
// I/O flag/port controller plus interrupt-entry and HLT sequencer for the 5-bit-opcode CPU.
// Stalls the core and strobes save_pc / pc_load_vec to vector it at VEC_ADDR.
module io_intr_sequencer
  import cpu_pkg::*;
#(
  parameter int                DATA_W   = 8,
  parameter int                ADDR_W   = 12,
  parameter logic [ADDR_W-1:0] VEC_ADDR = 12'h001
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_end,
  input  logic              rFI,
  input  logic              sFO,
  input  logic              rFO,
  input  logic              ION,
  input  logic              IOF,
  input  logic              hlt,
  input  logic              in_rd,
  input  logic              out_wr,
  input  logic [DATA_W-1:0] out_wdata,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [DATA_W-1:0] inpr,
  output logic              fgi,
  output logic              fgo,
  output logic              ien,
  output logic              stall,
  output logic              save_pc,
  output logic              pc_load_vec,
  output logic [ADDR_W-1:0] pc_vector,
  output dbg_t              dbg
);

  state_t state;
  logic   act;
  logic   wake;
  logic   in_rd_seen;

  // Strobes count only on an instruction boundary while the core is running.
  assign act       = instr_end && (state == RUN);
  assign wake      = ien && (fgi || fgo);
  assign pc_vector = VEC_ADDR;
  assign dbg       = '{state: state, in_rd_seen: in_rd_seen};

  io_port_regs #(.DATA_W(DATA_W)) u_ports (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .rfi       (act && rFI),
    .out_wr    (act && out_wr),
    .out_wdata (out_wdata),
    .sfo       (act && sFO),
    .rfo       (act && rFO),
    .out_ready (out_ready),
    .in_ready  (in_ready),
    .inpr      (inpr),
    .fgi       (fgi),
    .out_valid (out_valid),
    .out_data  (out_data),
    .fgo       (fgo)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      ien        <= 1'b0;
      in_rd_seen <= 1'b0;
    end else begin
      in_rd_seen <= act && in_rd;
      if (state == SAVE) begin
        ien <= 1'b0;
      end else if (act && IOF) begin
        ien <= 1'b0;
      end else if (act && ION) begin
        ien <= 1'b1;
      end
    end
  end

  // Outputs are assigned alongside the next state so they are registered decodes of it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      stall       <= 1'b0;
      save_pc     <= 1'b0;
      pc_load_vec <= 1'b0;
    end else begin
      save_pc     <= 1'b0;
      pc_load_vec <= 1'b0;
      unique case (state)
        RUN: begin
          stall <= 1'b0;
          // wake uses pre-edge flags, so an ION at this boundary waits for the next one.
          if (instr_end && wake) begin
            state   <= SAVE;
            stall   <= 1'b1;
            save_pc <= 1'b1;
          end else if (instr_end && hlt) begin
            state <= HALTED;
            stall <= 1'b1;
          end
        end
        SAVE: begin
          state       <= VEC;
          stall       <= 1'b1;
          pc_load_vec <= 1'b1;
        end
        VEC: begin
          state <= RUN;
          stall <= 1'b0;
        end
        HALTED: begin
          stall <= 1'b1;
          if (wake) begin
            state   <= SAVE;
            save_pc <= 1'b1;
          end
        end
        default: begin
          state <= RUN;
          stall <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_io_intr_sequencer.sv
// Directed bench for io_intr_sequencer: port handshakes, flag strobes, interrupt entry and HLT.
module tb_io_intr_sequencer;
  import cpu_pkg::*;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 12;

  logic              clk = 1'b0;
  logic              reset;
  logic              instr_end, rFI, sFO, rFO, ION, IOF, hlt, in_rd, out_wr;
  logic [DATA_W-1:0] out_wdata, in_data;
  logic              in_valid, out_ready;
  logic              in_ready, out_valid, fgi, fgo, ien, stall, save_pc, pc_load_vec;
  logic [DATA_W-1:0] out_data, inpr;
  logic [ADDR_W-1:0] pc_vector;
  dbg_t              dbg;

  int n_cmp = 0;
  int n_err = 0;

  // Clock / reset block
  always #5 clk = ~clk;

  io_intr_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .VEC_ADDR(12'h001)) dut (
    .clk(clk), .reset(reset), .instr_end(instr_end),
    .rFI(rFI), .sFO(sFO), .rFO(rFO), .ION(ION), .IOF(IOF), .hlt(hlt),
    .in_rd(in_rd), .out_wr(out_wr), .out_wdata(out_wdata),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .inpr(inpr), .fgi(fgi), .fgo(fgo), .ien(ien), .stall(stall),
    .save_pc(save_pc), .pc_load_vec(pc_load_vec), .pc_vector(pc_vector), .dbg(dbg)
  );

  // Driver tasks: inputs change and outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    instr_end = 0; rFI = 0; sFO = 0; rFO = 0; ION = 0; IOF = 0; hlt = 0;
    in_rd = 0; out_wr = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    idle();
    reset = 1; out_wdata = '0; in_data = '0; in_valid = 0; out_ready = 0;
    tick();
    tick();
    reset = 0;

    // Reset values
    chk("rst_fgi", 32'(fgi), 0);
    chk("rst_fgo", 32'(fgo), 1);
    chk("rst_ien", 32'(ien), 0);
    chk("rst_inpr", 32'(inpr), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_save_pc", 32'(save_pc), 0);
    chk("rst_pc_load_vec", 32'(pc_load_vec), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_state", 32'(dbg.state), 32'(RUN));
    chk("pc_vector", 32'(pc_vector), 32'h001);

    // Input port: accept, hold-off, rFI, second accept
    in_valid = 1; in_data = 8'hA5;
    tick();
    chk("in1_inpr", 32'(inpr), 32'hA5);
    chk("in1_fgi", 32'(fgi), 1);
    chk("in1_in_ready", 32'(in_ready), 0);
    in_data = 8'h3C;
    tick();
    chk("in2_held_inpr", 32'(inpr), 32'hA5);
    instr_end = 1; rFI = 1; in_rd = 1;
    tick();
    idle();
    chk("in_rfi_fgi", 32'(fgi), 0);
    chk("in_rfi_inpr", 32'(inpr), 32'hA5);
    chk("in_rd_seen", 32'(dbg.in_rd_seen), 1);
    tick();
    in_valid = 0;
    chk("in2_inpr", 32'(inpr), 32'h3C);
    chk("in2_fgi", 32'(fgi), 1);

    // Output port: load, ignored second OUT, device completion
    instr_end = 1; out_wr = 1; out_wdata = 8'h5A;
    tick();
    chk("out1_valid", 32'(out_valid), 1);
    chk("out1_fgo", 32'(fgo), 0);
    chk("out1_data", 32'(out_data), 32'h5A);
    out_wdata = 8'h11;
    tick();
    idle();
    chk("out2_ignored", 32'(out_data), 32'h5A);
    chk("out2_valid", 32'(out_valid), 1);
    out_ready = 1;
    tick();
    out_ready = 0;
    chk("out_done_valid", 32'(out_valid), 0);
    chk("out_done_fgo", 32'(fgo), 1);
    chk("out_done_data", 32'(out_data), 32'h5A);

    // Interrupt entry: ION at one boundary, entry at the next
    instr_end = 1; ION = 1;
    tick();
    idle();
    chk("ion_ien", 32'(ien), 1);
    chk("ion_no_entry", 32'(stall), 0);
    chk("ion_no_save", 32'(save_pc), 0);
    tick(); tick(); tick();
    chk("ion_wait_stall", 32'(stall), 0);
    instr_end = 1;
    tick();
    idle();
    chk("irq_save_pc", 32'(save_pc), 1);
    chk("irq_save_stall", 32'(stall), 1);
    chk("irq_save_state", 32'(dbg.state), 32'(SAVE));
    tick();
    chk("irq_vec_load", 32'(pc_load_vec), 1);
    chk("irq_vec_save_off", 32'(save_pc), 0);
    chk("irq_vec_stall", 32'(stall), 1);
    chk("irq_vec_pc", 32'(pc_vector), 32'h001);
    tick();
    chk("irq_run_stall", 32'(stall), 0);
    chk("irq_run_load_off", 32'(pc_load_vec), 0);
    chk("irq_run_ien", 32'(ien), 0);
    instr_end = 1; rFI = 1;
    tick();
    idle();
    chk("clr_fgi", 32'(fgi), 0);

    // HLT with IEN=0 stays halted; strobes ignored; reset recovers
    instr_end = 1; hlt = 1;
    tick();
    idle();
    chk("hlt_stall", 32'(stall), 1);
    chk("hlt_state", 32'(dbg.state), 32'(HALTED));
    for (int i = 0; i < 22; i++) begin
      instr_end = (i == 5); ION = (i == 5);
      tick();
      chk("hlt_hold_stall", 32'(stall), 1);
    end
    idle();
    chk("hlt_ion_ignored", 32'(ien), 0);
    reset = 1;
    tick();
    reset = 0;
    chk("hlt_rst_stall", 32'(stall), 0);
    chk("hlt_rst_fgo", 32'(fgo), 1);
    chk("hlt_rst_ien", 32'(ien), 0);
    chk("hlt_rst_state", 32'(dbg.state), 32'(RUN));

    // HLT with IEN=1, no flags; an input byte wakes it into the interrupt sequence
    instr_end = 1; rFO = 1;
    tick();
    idle();
    chk("rfo_fgo", 32'(fgo), 0);
    instr_end = 1; ION = 1;
    tick();
    idle();
    chk("ion2_ien", 32'(ien), 1);
    instr_end = 1; hlt = 1;
    tick();
    idle();
    chk("hlt2_stall", 32'(stall), 1);
    chk("hlt2_no_save", 32'(save_pc), 0);
    tick();
    chk("hlt2_still", 32'(dbg.state), 32'(HALTED));
    in_valid = 1; in_data = 8'h77;
    tick();
    in_valid = 0;
    chk("wake_fgi", 32'(fgi), 1);
    chk("wake_inpr", 32'(inpr), 32'h77);
    tick();
    chk("wake_save_pc", 32'(save_pc), 1);
    chk("wake_save_state", 32'(dbg.state), 32'(SAVE));
    tick();
    chk("wake_vec_load", 32'(pc_load_vec), 1);
    chk("wake_vec_stall", 32'(stall), 1);
    tick();
    chk("wake_run_stall", 32'(stall), 0);
    chk("wake_run_ien", 32'(ien), 0);

    // ION and IOF together: IOF wins
    instr_end = 1; rFI = 1;
    tick();
    instr_end = 0; rFI = 0;
    chk("clr2_fgi", 32'(fgi), 0);
    instr_end = 1; ION = 1;
    tick();
    instr_end = 0; ION = 0;
    chk("ion3_ien", 32'(ien), 1);
    instr_end = 1; ION = 1; IOF = 1;
    tick();
    idle();
    chk("ion_iof_ien", 32'(ien), 0);
    chk("ion_iof_stall", 32'(stall), 0);

    // rFI coincident with an accept: set wins
    in_valid = 1; in_data = 8'hC3; instr_end = 1; rFI = 1;
    tick();
    idle();
    in_valid = 0;
    chk("rfi_accept_fgi", 32'(fgi), 1);
    chk("rfi_accept_inpr", 32'(inpr), 32'hC3);

    // rFO coincident with device completion: rFO wins
    instr_end = 1; out_wr = 1; out_wdata = 8'h99;
    tick();
    idle();
    chk("out3_valid", 32'(out_valid), 1);
    instr_end = 1; rFO = 1; out_ready = 1;
    tick();
    idle();
    out_ready = 0;
    chk("rfo_done_valid", 32'(out_valid), 0);
    chk("rfo_done_fgo", 32'(fgo), 0);
    chk("out3_data", 32'(out_data), 32'h99);

    // sFO sets FGO without touching out_valid
    instr_end = 1; sFO = 1;
    tick();
    idle();
    chk("sfo_fgo", 32'(fgo), 1);
    chk("sfo_valid", 32'(out_valid), 0);

    // Final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
